// File: rtl/spartan_sram_slave_if.sv
// rtl/spartan_sram_slave_if.sv - Spartan request/response channel pair
interface spartan_sram_slave_if #(
    parameter int BWIDTH = 64
);
    logic [BWIDTH+1:0] SpMBUS;
    logic              SpMVLD;
    logic              SpMRDY;
    logic [BWIDTH+1:0] SpSBUS;
    logic              SpSVLD;
    logic              SpSRDY;

    modport master (
        output SpMBUS,
        output SpMVLD,
        input  SpMRDY,
        input  SpSBUS,
        input  SpSVLD,
        output SpSRDY
    );

    modport slave (
        input  SpMBUS,
        input  SpMVLD,
        output SpMRDY,
        output SpSBUS,
        output SpSVLD,
        input  SpSRDY
    );
endinterface

// File: rtl/spartan_sram_slave.sv
// rtl/spartan_sram_slave.sv - Spartan bus target backed by a synchronous RAM
module spartan_sram_slave #(
    parameter int BWIDTH = 64,
    parameter int AWIDTH = 8
) (
    input logic                 CLK,
    input logic                 RST,
    spartan_sram_slave_if.slave sp
);
    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic [2:0] {IDLE, WDATA, WACK, RHDR, RDATA, DROP} stateT;

    stateT             state;
    logic [BWIDTH-1:0] mem [DEPTH];
    logic [BWIDTH-1:0] ramQ;
    logic [AWIDTH-1:0] baseAddr;
    logic [AWIDTH-1:0] rdAddr;
    logic [AWIDTH-1:0] wrAddr;
    logic [1:0]        hdrCmd;
    logic [3:0]        hdrLen;
    logic [7:0]        hdrId;
    logic [4:0]        beatCnt;
    logic              errFlag;
    logic              mRdy;
    logic              sVld;
    logic [BWIDTH+1:0] sBus;

    logic              inSop;
    logic              inEop;
    logic [1:0]        inCmd;
    logic [3:0]        inLen;
    logic [7:0]        inId;
    logic [AWIDTH-1:0] inAddr;
    logic [BWIDTH-1:0] inData;
    logic              mHs;
    logic              sHs;
    logic [4:0]        lenP1;
    logic              wLast;
    logic              wErr;
    logic              rdLast;
    logic              loadBeat;
    logic              memWe;

    assign inSop  = sp.SpMBUS[BWIDTH+1];
    assign inEop  = sp.SpMBUS[BWIDTH];
    assign inCmd  = sp.SpMBUS[BWIDTH-1 -: 2];
    assign inLen  = sp.SpMBUS[BWIDTH-3 -: 4];
    assign inId   = sp.SpMBUS[BWIDTH-7 -: 8];
    assign inAddr = sp.SpMBUS[AWIDTH-1:0];
    assign inData = sp.SpMBUS[BWIDTH-1:0];

    assign mHs    = sp.SpMVLD & mRdy;
    assign sHs    = sVld & sp.SpSRDY;
    assign lenP1  = {1'b0, hdrLen} + 5'd1;
    assign wLast  = (beatCnt == {1'b0, hdrLen});
    assign wErr   = errFlag | inSop | (inEop ^ wLast);
    assign rdLast = (beatCnt == lenP1);

    assign loadBeat = sHs & ((state == RHDR) | ((state == RDATA) & ~rdLast));
    assign wrAddr   = baseAddr + AWIDTH'(beatCnt);
    assign memWe    = RST & (state == WDATA) & mHs;

    assign sp.SpMRDY = mRdy;
    assign sp.SpSVLD = sVld;
    assign sp.SpSBUS = sBus;

    function automatic logic [BWIDTH-1:0] rspHdr(input logic [1:0] cmd, input logic [3:0] len,
                                                 input logic [7:0] id, input logic st);
        logic [BWIDTH-1:0] p;
        p                  = '0;
        p[BWIDTH-1 -: 2]   = cmd;
        p[BWIDTH-3 -: 4]   = len;
        p[BWIDTH-7 -: 8]   = id;
        p[BWIDTH-15]       = st;
        return p;
    endfunction

    // ramQ always holds the word for the next read beat, so the output
    // register can reload on every handshake without a bubble.
    always_comb begin
        rdAddr = baseAddr + AWIDTH'(beatCnt);
        if (state == IDLE) begin
            rdAddr = inAddr;
        end else if (loadBeat) begin
            rdAddr = baseAddr + AWIDTH'(beatCnt + 5'd1);
        end
    end

    always_ff @(posedge CLK) begin
        if (memWe) begin
            mem[wrAddr] <= inData;
        end
        ramQ <= mem[rdAddr];
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            mRdy     <= 1'b0;
            sVld     <= 1'b0;
            sBus     <= '0;
            beatCnt  <= '0;
            errFlag  <= 1'b0;
            hdrCmd   <= '0;
            hdrLen   <= '0;
            hdrId    <= '0;
            baseAddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mRdy <= 1'b1;
                    if (mHs && inSop) begin
                        hdrCmd   <= inCmd;
                        hdrLen   <= inLen;
                        hdrId    <= inId;
                        baseAddr <= inAddr;
                        beatCnt  <= '0;
                        errFlag  <= 1'b0;
                        if (inCmd == 2'b00) begin
                            state <= RHDR;
                            mRdy  <= 1'b0;
                            sVld  <= 1'b1;
                            sBus  <= {2'b10, rspHdr(inCmd, inLen, inId, 1'b0)};
                        end else if (inEop) begin
                            state <= WACK;
                            mRdy  <= 1'b0;
                            sVld  <= 1'b1;
                            sBus  <= {2'b11, rspHdr(inCmd, inLen, inId, 1'b1)};
                        end else if (inCmd == 2'b01) begin
                            state <= WDATA;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                WDATA: begin
                    if (mHs) begin
                        if (wLast) begin
                            state <= WACK;
                            mRdy  <= 1'b0;
                            sVld  <= 1'b1;
                            sBus  <= {2'b11, rspHdr(hdrCmd, hdrLen, hdrId, wErr)};
                        end else begin
                            errFlag <= wErr;
                            beatCnt <= beatCnt + 5'd1;
                        end
                    end
                end
                DROP: begin
                    if (mHs && inEop) begin
                        state <= WACK;
                        mRdy  <= 1'b0;
                        sVld  <= 1'b1;
                        sBus  <= {2'b11, rspHdr(hdrCmd, hdrLen, hdrId, 1'b1)};
                    end
                end
                WACK: begin
                    if (sHs) begin
                        state <= IDLE;
                        sVld  <= 1'b0;
                        mRdy  <= 1'b1;
                    end
                end
                RHDR: begin
                    if (sHs) begin
                        state   <= RDATA;
                        sBus    <= {1'b0, (hdrLen == 4'd0), ramQ};
                        beatCnt <= 5'd1;
                    end
                end
                RDATA: begin
                    if (sHs) begin
                        if (rdLast) begin
                            state <= IDLE;
                            sVld  <= 1'b0;
                            mRdy  <= 1'b1;
                        end else begin
                            sBus    <= {1'b0, (beatCnt == {1'b0, hdrLen}), ramQ};
                            beatCnt <= beatCnt + 5'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    mRdy  <= 1'b0;
                    sVld  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spartan_sram_slave.sv
// tb/tb_spartan_sram_slave.sv - randomized bench for spartan_sram_slave against a packet-level model
module tb_spartan_sram_slave;
    localparam int BW    = 64;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    typedef logic [BW+1:0] beatT;

    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    spartan_sram_slave_if #(.BWIDTH(BW)) bus ();

    spartan_sram_slave #(.BWIDTH(BW), .AWIDTH(AW)) dut (
        .CLK (clk),
        .RST (rstN),
        .sp  (bus)
    );

    logic [BW-1:0] refMem [DEPTH];
    beatT          reqQ[$];
    beatT          expQ[$];
    int            nChecks = 0;
    int            nErrors = 0;

    task automatic check(input string tag, input beatT got, input beatT exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] pkHdr(input logic [1:0] cmd, input logic [3:0] len,
                                            input logic [7:0] id, input logic st,
                                            input logic [31:0] addr);
        logic [BW-1:0] p;
        p            = '0;
        p[BW-1 -: 2] = cmd;
        p[BW-3 -: 4] = len;
        p[BW-7 -: 8] = id;
        p[BW-15]     = st;
        p[31:0]      = addr;
        return p;
    endfunction

    function automatic beatT mkBeat(input bit sop, input bit eop, input logic [BW-1:0] p);
        return {sop, eop, p};
    endfunction

    function automatic int memIdx(input logic [31:0] a, input int k);
        return int'((a + 32'(k)) % 32'(DEPTH));
    endfunction

    task automatic pushHdr(input bit eop, input logic [1:0] cmd, input int len,
                           input logic [7:0] id, input logic [31:0] a);
        reqQ.push_back(mkBeat(1'b1, eop, pkHdr(cmd, 4'(len), id, 1'b0, a)));
    endtask

    task automatic pushData(input logic [BW-1:0] d, input bit sop, input bit eop);
        reqQ.push_back(mkBeat(sop, eop, d));
    endtask

    // Packet-level reference: interprets the request and predicts the response beats.
    task automatic model();
        int            i = 0;
        beatT          h;
        logic [1:0]    cmd;
        logic [3:0]    len;
        logic [7:0]    id;
        logic [31:0]   a;
        logic          st;
        beatT          d;
        while (i < reqQ.size() && !reqQ[i][BW+1]) i++;
        h   = reqQ[i];
        cmd = h[BW-1 -: 2];
        len = h[BW-3 -: 4];
        id  = h[BW-7 -: 8];
        a   = h[31:0];
        if (cmd == 2'b00) begin
            expQ.push_back(mkBeat(1'b1, 1'b0, pkHdr(cmd, len, id, 1'b0, 32'h0)));
            for (int k = 0; k <= int'(len); k++)
                expQ.push_back(mkBeat(1'b0, k == int'(len), refMem[memIdx(a, k)]));
        end else if (cmd == 2'b01 && !h[BW]) begin
            st = 1'b0;
            for (int k = 0; k <= int'(len); k++) begin
                d = reqQ[i + 1 + k];
                if (d[BW+1]) st = 1'b1;
                if (d[BW] != (k == int'(len))) st = 1'b1;
                refMem[memIdx(a, k)] = d[BW-1:0];
            end
            expQ.push_back(mkBeat(1'b1, 1'b1, pkHdr(cmd, len, id, st, 32'h0)));
        end else begin
            expQ.push_back(mkBeat(1'b1, 1'b1, pkHdr(cmd, len, id, 1'b1, 32'h0)));
        end
    endtask

    task automatic sendReq();
        int cyc = 0;
        bit ok;
        foreach (reqQ[j]) begin
            bus.SpMBUS = reqQ[j];
            bus.SpMVLD = 1'b1;
            do begin
                ok = bus.SpMRDY;
                @(negedge clk);
                cyc++;
            end while (!ok && cyc < 100);
        end
        bus.SpMVLD = 1'b0;
        bus.SpMBUS = '0;
        check("req_cycles", beatT'(cyc), beatT'(reqQ.size()));
        check("rsp_latency", beatT'(bus.SpSVLD), beatT'(1));
    endtask

    task automatic recvResp(input int mode);
        int   cyc  = 0;
        int   nExp = expQ.size();
        bit   rdy;
        bit   hv   = 1'b0;
        beatT held = '0;
        while (expQ.size() > 0 && cyc < 1000) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.SpSRDY = rdy;
            if (hv) begin
                check("stall_vld", beatT'(bus.SpSVLD), beatT'(1));
                check("stall_bus", bus.SpSBUS, held);
            end
            hv = 1'b0;
            if (bus.SpSVLD) begin
                if (rdy) begin
                    check("rsp_beat", bus.SpSBUS, expQ.pop_front());
                end else begin
                    hv   = 1'b1;
                    held = bus.SpSBUS;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (expQ.size() > 0) begin
            check("rsp_timeout", beatT'(expQ.size()), beatT'(0));
            expQ.delete();
        end
        if (mode == 0) check("rsp_cycles", beatT'(cyc), beatT'(nExp));
        bus.SpSRDY = 1'b0;
        check("b2b_rdy", beatT'(bus.SpMRDY), beatT'(1));
        check("rsp_done", beatT'(bus.SpSVLD), beatT'(0));
    endtask

    task automatic doTxn(input int mode);
        model();
        sendReq();
        recvResp(mode);
        reqQ.delete();
    endtask

    initial begin
        logic [BW-1:0] d;
        int            kind;
        int            len;
        int            n;
        int            bad;

        rstN       = 1'b0;
        bus.SpMVLD = 1'b0;
        bus.SpMBUS = '0;
        bus.SpSRDY = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_vld", beatT'(bus.SpSVLD), beatT'(0));
        check("reset_bus", bus.SpSBUS, beatT'(0));
        check("reset_rdy", beatT'(bus.SpMRDY), beatT'(0));
        rstN = 1'b1;
        @(negedge clk);
        check("rdy_after_reset", beatT'(bus.SpMRDY), beatT'(1));

        for (int blk = 0; blk < DEPTH / 16; blk++) begin
            pushHdr(1'b0, 2'b01, 15, 8'(blk), 32'(blk * 16));
            for (int k = 0; k < 16; k++) pushData({$urandom, $urandom}, 1'b0, k == 15);
            doTxn(2);
        end

        pushHdr(1'b0, 2'b01, 3, 8'h5A, 32'h10);
        for (int k = 0; k < 4; k++) pushData(BW'(64'hA0 + k), 1'b0, k == 3);
        doTxn(0);
        pushHdr(1'b1, 2'b00, 3, 8'h5B, 32'h10);
        doTxn(0);

        pushHdr(1'b0, 2'b01, 1, 8'h11, 32'(DEPTH - 1));
        pushData(BW'(64'hB0), 1'b0, 1'b0);
        pushData(BW'(64'hB1), 1'b0, 1'b1);
        doTxn(0);
        pushHdr(1'b0, 2'b00, 1, 8'h12, 32'hFFFF_FFFF);
        doTxn(0);

        pushHdr(1'b1, 2'b00, 15, 8'h20, 32'h80);
        doTxn(1);

        pushHdr(1'b0, 2'b01, 2, 8'h30, 32'h30);
        pushData(BW'(64'hC0), 1'b0, 1'b0);
        pushData(BW'(64'hC1), 1'b0, 1'b1);
        pushData(BW'(64'hC2), 1'b0, 1'b1);
        doTxn(0);
        pushHdr(1'b0, 2'b10, 1, 8'h31, 32'h0);
        pushData(BW'(64'hDEAD), 1'b0, 1'b1);
        doTxn(0);
        pushHdr(1'b1, 2'b01, 2, 8'h32, 32'h30);
        doTxn(0);
        pushHdr(1'b1, 2'b00, 2, 8'h33, 32'h30);
        doTxn(2);

        d = {$urandom, $urandom};
        bus.SpMBUS = mkBeat(1'b1, 1'b0, pkHdr(2'b01, 4'd3, 8'h40, 1'b0, 32'h40));
        bus.SpMVLD = 1'b1;
        @(negedge clk);
        bus.SpMBUS = mkBeat(1'b0, 1'b0, d);
        @(negedge clk);
        bus.SpMVLD = 1'b0;
        bus.SpMBUS = '0;
        refMem[8'h40] = d;
        rstN = 1'b0;
        @(negedge clk);
        check("abort_vld", beatT'(bus.SpSVLD), beatT'(0));
        check("abort_rdy", beatT'(bus.SpMRDY), beatT'(0));
        rstN = 1'b1;
        @(negedge clk);
        check("abort_rdy_after", beatT'(bus.SpMRDY), beatT'(1));
        pushHdr(1'b1, 2'b00, 1, 8'h41, 32'h40);
        doTxn(0);

        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) pushData({$urandom, $urandom}, 1'b0, 1'($urandom));
            if (kind <= 3) begin
                pushHdr(1'($urandom), 2'b00, len, 8'($urandom), $urandom);
            end else if (kind <= 7) begin
                bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
                pushHdr(1'b0, 2'b01, len, 8'($urandom), $urandom);
                for (int k = 0; k <= len; k++) begin
                    if (k == bad) pushData({$urandom, $urandom}, 1'($urandom), !(k == len));
                    else          pushData({$urandom, $urandom}, 1'b0, k == len);
                end
            end else if (kind == 8) begin
                n = $urandom_range(1, 3);
                pushHdr(n == 1, 2'($urandom_range(2, 3)), len, 8'($urandom), $urandom);
                for (int k = 1; k < n; k++) pushData({$urandom, $urandom}, 1'($urandom), k == n - 1);
            end else begin
                pushHdr(1'b1, 2'b01, len, 8'($urandom), $urandom);
            end
            doTxn($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule
